// File: rtl/register_file_wb.sv
// register_file_wb
// ----------------
// Architectural register file and write-back endpoint of the 16-bit pipeline.
// It accepts one MEM/WB write-back per cycle, which may be a two-register
// write for a swap. It also delivers the two ID-stage operand reads,
// registered into the ID/EX boundary.
//
// A write committing on the same edge as a read of that register is bypassed
// straight into the read data. This covers the WB->ID hazard that the
// stage-3 forwarding unit does not see.
//
// Ports:
//   clk            pipeline clock, all state updates on the rising edge
//   rst            synchronous, active-low reset
//   MEMWBregWrite  00 none, 01 write op1, 10 write op1+op2 (swap), 11 reserved
//   MEMWBop1/op2   destination indices for wdata1/wdata2
//   wdata1/wdata2  write-back data
//   IFIDop1/op2    read indices A/B
//   rdata1/rdata2  registered read data A/B (1-cycle latency)
//   wr_count       saturating count of committed register writes
//   wr_err         sticky flag: reserved code or swap collision seen

module register_file_wb #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        MEMWBregWrite,
   input  logic [ADDR_W-1:0] MEMWBop1,
   input  logic [ADDR_W-1:0] MEMWBop2,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [DATA_W-1:0] wdata2,
   input  logic [ADDR_W-1:0] IFIDop1,
   input  logic [ADDR_W-1:0] IFIDop2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   output logic [15:0]       wr_count,
   output logic              wr_err
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];

   logic              isSingle;
   logic              isSwap;
   logic              isReserved;
   logic              collision;
   logic              op1Zero;
   logic              op2Zero;
   logic              we1;
   logic              we2;
   logic              errSet;
   logic [1:0]        writeInc;
   logic [16:0]       countSum;
   logic [15:0]       countNext;
   logic [DATA_W-1:0] readA;
   logic [DATA_W-1:0] readB;

   // Returns the value a read port should capture this edge.
   // Register 0 reads as zero when hardwired, even if a write targets it.
   // Otherwise a write committing this edge overrides the stored value.
   // Port 1 is checked first so that it wins, which matches the write rule.
   function automatic logic [DATA_W-1:0] bypassRead(
      input logic [ADDR_W-1:0] idx,
      input logic [DATA_W-1:0] stored,
      input logic              en1,
      input logic [ADDR_W-1:0] dst1,
      input logic [DATA_W-1:0] val1,
      input logic              en2,
      input logic [ADDR_W-1:0] dst2,
      input logic [DATA_W-1:0] val2
   );
      logic [DATA_W-1:0] result;
      result = stored;
      if ((ZERO_REG != 0) && (idx == '0)) begin
         result = '0;
      end else if (en1 && (idx == dst1)) begin
         result = val1;
      end else if (en2 && (idx == dst2)) begin
         result = val2;
      end
      return result;
   endfunction

   // Decode the write-back code into per-port write enables.
   // A swap onto a single index keeps only the op1 write, so that register
   // is modified (and counted) once. Writes to a hardwired register 0 are
   // dropped before they reach the enables, so they are never counted.
   // The counter adds the number of registers really modified and clamps
   // at all-ones instead of wrapping.
   always_comb begin
      isSingle   = (MEMWBregWrite == 2'b01);
      isSwap     = (MEMWBregWrite == 2'b10);
      isReserved = (MEMWBregWrite == 2'b11);
      collision  = (MEMWBop1 == MEMWBop2);
      op1Zero    = (ZERO_REG != 0) && (MEMWBop1 == '0);
      op2Zero    = (ZERO_REG != 0) && (MEMWBop2 == '0);
      we1        = (isSingle || isSwap) && !op1Zero;
      we2        = isSwap && !collision && !op2Zero;
      errSet     = isReserved || (isSwap && collision);
      writeInc   = {1'b0, we1} + {1'b0, we2};
      countSum   = {1'b0, wr_count} + {15'b0, writeInc};
      countNext  = countSum[16] ? 16'hFFFF : countSum[15:0];
   end

   // Compute the read data for both ports, with write-through bypass.
   always_comb begin
      readA = bypassRead(IFIDop1, regs[IFIDop1], we1, MEMWBop1, wdata1,
                         we2, MEMWBop2, wdata2);
      readB = bypassRead(IFIDop2, regs[IFIDop2], we1, MEMWBop1, wdata1,
                         we2, MEMWBop2, wdata2);
   end

   // State update: storage, registered reads, write counter and error flag.
   // Reset wins over any write presented in the same cycle. The first edge
   // after reset is released is an ordinary cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         rdata1   <= '0;
         rdata2   <= '0;
         wr_count <= '0;
         wr_err   <= 1'b0;
      end else begin
         if (we1) begin
            regs[MEMWBop1] <= wdata1;
         end
         if (we2) begin
            regs[MEMWBop2] <= wdata2;
         end
         rdata1   <= readA;
         rdata2   <= readB;
         wr_count <= countNext;
         if (errSet) begin
            wr_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_register_file_wb.sv
// tb_register_file_wb
// -------------------
// Directed bench for register_file_wb. Each vector is driven for one clock
// edge, and the outputs are then compared against hand-computed values.

module tb_register_file_wb;

   logic        clk;
   logic        rst;
   logic [1:0]  regWrite;
   logic [3:0]  wbOp1;
   logic [3:0]  wbOp2;
   logic [15:0] wdata1;
   logic [15:0] wdata2;
   logic [3:0]  idOp1;
   logic [3:0]  idOp2;
   logic [15:0] rdata1;
   logic [15:0] rdata2;
   logic [15:0] wrCount;
   logic        wrErr;

   int errorCount = 0;
   int checkCount = 0;

   register_file_wb #(
      .DATA_W(16),
      .ADDR_W(4),
      .ZERO_REG(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .MEMWBregWrite(regWrite),
      .MEMWBop1(wbOp1),
      .MEMWBop2(wbOp2),
      .wdata1(wdata1),
      .wdata2(wdata2),
      .IFIDop1(idOp1),
      .IFIDop2(idOp2),
      .rdata1(rdata1),
      .rdata2(rdata2),
      .wr_count(wrCount),
      .wr_err(wrErr)
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one cycle of inputs, then waits for the edge that consumes them.
   // Outputs are left settled 1 time unit after that edge.
   task automatic applyStimulus(
      input logic        rstVal,
      input logic [1:0]  code,
      input logic [3:0]  o1,
      input logic [3:0]  o2,
      input logic [15:0] w1,
      input logic [15:0] w2,
      input logic [3:0]  r1,
      input logic [3:0]  r2
   );
      rst      = rstVal;
      regWrite = code;
      wbOp1    = o1;
      wbOp2    = o2;
      wdata1   = w1;
      wdata2   = w2;
      idOp1    = r1;
      idOp2    = r2;
      @(posedge clk);
      #1;
   endtask

   // Single comparison point for every check in the bench.
   task automatic checkOutput(
      input string       tag,
      input logic [31:0] observed,
      input logic [31:0] expected
   );
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      rst      = 1'b0;
      regWrite = 2'b00;
      wbOp1    = '0;
      wbOp2    = '0;
      wdata1   = '0;
      wdata2   = '0;
      idOp1    = '0;
      idOp2    = '0;

      // Hold reset for two edges while a write to r3 is presented.
      applyStimulus(1'b0, 2'b01, 4'd3, 4'd0, 16'h1234, 16'h0000, 4'd3, 4'd3);
      applyStimulus(1'b0, 2'b01, 4'd3, 4'd0, 16'h1234, 16'h0000, 4'd3, 4'd3);
      checkOutput("rst_rdata1", {16'h0, rdata1}, 32'h0);
      checkOutput("rst_rdata2", {16'h0, rdata2}, 32'h0);
      checkOutput("rst_count", {16'h0, wrCount}, 32'h0);
      checkOutput("rst_err", {31'h0, wrErr}, 32'h0);

      // r3 must still be zero because the write was blocked by reset.
      applyStimulus(1'b1, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 4'd3, 4'd0);
      checkOutput("post_rst_r3", {16'h0, rdata1}, 32'h0);
      checkOutput("post_rst_count", {16'h0, wrCount}, 32'h0);

      // Single write with a same-cycle read of r5 on both ports (bypass).
      applyStimulus(1'b1, 2'b01, 4'd5, 4'd0, 16'hBEEF, 16'h0000, 4'd5, 4'd5);
      checkOutput("bypass_r5_a", {16'h0, rdata1}, 32'h0000_BEEF);
      checkOutput("bypass_r5_b", {16'h0, rdata2}, 32'h0000_BEEF);
      checkOutput("single_count", {16'h0, wrCount}, 32'd1);

      // Preload r3 and r6, then swap their contents.
      applyStimulus(1'b1, 2'b01, 4'd3, 4'd0, 16'h0003, 16'h0000, 4'd0, 4'd0);
      applyStimulus(1'b1, 2'b01, 4'd6, 4'd0, 16'h0006, 16'h0000, 4'd0, 4'd0);
      checkOutput("preload_count", {16'h0, wrCount}, 32'd3);
      applyStimulus(1'b1, 2'b10, 4'd3, 4'd6, 16'h0006, 16'h0003, 4'd3, 4'd6);
      checkOutput("swap_bypass_r3", {16'h0, rdata1}, 32'h0000_0006);
      checkOutput("swap_bypass_r6", {16'h0, rdata2}, 32'h0000_0003);
      checkOutput("swap_count", {16'h0, wrCount}, 32'd5);
      applyStimulus(1'b1, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 4'd3, 4'd6);
      checkOutput("swap_stored_r3", {16'h0, rdata1}, 32'h0000_0006);
      checkOutput("swap_stored_r6", {16'h0, rdata2}, 32'h0000_0003);

      // Swap that targets r0: only the r4 half commits.
      applyStimulus(1'b1, 2'b10, 4'd0, 4'd4, 16'hFFFF, 16'h00AA, 4'd0, 4'd4);
      checkOutput("zero_bypass_r0", {16'h0, rdata1}, 32'h0);
      checkOutput("zero_bypass_r4", {16'h0, rdata2}, 32'h0000_00AA);
      checkOutput("zero_count", {16'h0, wrCount}, 32'd6);
      checkOutput("zero_no_err", {31'h0, wrErr}, 32'h0);
      applyStimulus(1'b1, 2'b01, 4'd0, 4'd0, 16'h5555, 16'h0000, 4'd0, 4'd4);
      checkOutput("zero_single_r0", {16'h0, rdata1}, 32'h0);
      checkOutput("zero_stored_r4", {16'h0, rdata2}, 32'h0000_00AA);
      checkOutput("zero_single_count", {16'h0, wrCount}, 32'd6);

      // Swap collision on r7: wdata1 wins, one write is counted, error is set.
      applyStimulus(1'b1, 2'b10, 4'd7, 4'd7, 16'h1111, 16'h2222, 4'd7, 4'd7);
      checkOutput("coll_bypass_a", {16'h0, rdata1}, 32'h0000_1111);
      checkOutput("coll_bypass_b", {16'h0, rdata2}, 32'h0000_1111);
      checkOutput("coll_count", {16'h0, wrCount}, 32'd7);
      checkOutput("coll_err", {31'h0, wrErr}, 32'h1);

      // The reserved code writes nothing, and the error flag stays set.
      applyStimulus(1'b1, 2'b11, 4'd5, 4'd7, 16'hDEAD, 16'hCAFE, 4'd5, 4'd7);
      checkOutput("rsv_r5", {16'h0, rdata1}, 32'h0000_BEEF);
      checkOutput("rsv_r7", {16'h0, rdata2}, 32'h0000_1111);
      checkOutput("rsv_count", {16'h0, wrCount}, 32'd7);
      applyStimulus(1'b1, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 4'd0, 4'd0);
      checkOutput("err_sticky", {31'h0, wrErr}, 32'h1);

      // A second reset clears the error flag, the counter and the storage.
      applyStimulus(1'b0, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 4'd5, 4'd7);
      checkOutput("rst2_err", {31'h0, wrErr}, 32'h0);
      checkOutput("rst2_count", {16'h0, wrCount}, 32'h0);
      applyStimulus(1'b1, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 4'd5, 4'd7);
      checkOutput("rst2_r5", {16'h0, rdata1}, 32'h0);
      checkOutput("rst2_r7", {16'h0, rdata2}, 32'h0);

      // Bring the counter to 16'hFFFE with 32767 swaps of r1/r2.
      for (int i = 0; i < 32767; i++) begin
         applyStimulus(1'b1, 2'b10, 4'd1, 4'd2, 16'(i), ~16'(i), 4'd0, 4'd0);
      end
      checkOutput("preload_fffe", {16'h0, wrCount}, 32'h0000_FFFE);
      applyStimulus(1'b1, 2'b10, 4'd8, 4'd9, 16'h0808, 16'h0909, 4'd1, 4'd2);
      checkOutput("sat_count", {16'h0, wrCount}, 32'h0000_FFFF);
      checkOutput("sat_last_r1", {16'h0, rdata1}, 32'h0000_7FFE);
      checkOutput("sat_last_r2", {16'h0, rdata2}, 32'h0000_8001);
      applyStimulus(1'b1, 2'b01, 4'd10, 4'd0, 16'h0A0A, 16'h0000, 4'd8, 4'd9);
      checkOutput("sat_hold", {16'h0, wrCount}, 32'h0000_FFFF);
      checkOutput("sat_r8", {16'h0, rdata1}, 32'h0000_0808);
      checkOutput("sat_r9", {16'h0, rdata2}, 32'h0000_0909);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
